gr8ram_dram_sched: RTL and testbench



---
 rtl/gr8ram_pkg.sv | 30 +++
 rtl/gr8ram_ref_timer.sv | 46 ++++
 rtl/gr8ram_dram_sched.sv | 166 ++++++++++++++++
 tb/tb_gr8ram_dram_sched.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/gr8ram_pkg.sv
// Shared definitions for the GR8RAM DRAM scheduler.
//   sched_state_t : scheduler FSM states (access and refresh paths)
//   address field positions, requester IDs, strobe bundle type
package gr8ram_pkg;

   typedef enum logic [2:0] {
      S_IDLE, S_ROW, S_COL, S_HOLD, S_PRE, S_RCAS, S_RRAS, S_RHOLD
   } sched_state_t;

   localparam int BANK_BIT = 22;
   localparam int ROW_HI   = 21;
   localparam int ROW_LO   = 11;
   localparam int COL_HI   = 10;
   localparam int COL_LO   = 0;

   localparam logic GNT_HOST = 1'b0;
   localparam logic GNT_DMA  = 1'b1;

   // DRAM strobes (active low) plus the row/column mux select
   typedef struct packed {
      logic nras;
      logic ncas0;
      logic ncas1;
      logic nrwe;
      logic casel;
   } strobe_t;

   localparam strobe_t STB_IDLE = strobe_t'(5'b11110);

endpackage

// File: rtl/gr8ram_ref_timer.sv
// Refresh tick generator with saturating pending-refresh counter.
//   clk, rst   : clock, async active-high reset
//   tick_done  : high in the last refresh cycle (RHOLD); retires one refresh
//   pending    : refreshes owed, saturates at REF_MAX
//   urgent     : pending == REF_MAX
//   ref_ovf    : sticky, a tick arrived while saturated
module gr8ram_ref_timer #(
   parameter  int REF_PERIOD = 109,
   parameter  int REF_MAX    = 3,
   localparam int PW         = $clog2(REF_MAX + 1),
   localparam int CW         = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tick_done,
   output logic [PW-1:0] pending,
   output logic          urgent,
   output logic          ref_ovf
);

   logic [CW-1:0] cnt;
   logic          tick;

   assign tick   = (cnt == CW'(REF_PERIOD - 1));
   assign urgent = (pending == PW'(REF_MAX));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         pending <= '0;
         ref_ovf <= 1'b0;
      end else begin
         cnt <= tick ? '0 : cnt + 1'b1;
         // a tick and a retire in the same cycle cancel out
         case ({tick, tick_done})
            2'b10: begin
               if (urgent) ref_ovf <= 1'b1;
               else        pending <= pending + 1'b1;
            end
            2'b01: if (pending != '0) pending <= pending - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/gr8ram_dram_sched.sv
// DRAM access scheduler: arbitrates host, DMA and CBR refresh onto the
// two-bank DRAM and drives RAS/CAS/WE/address-mux.
//   C7M, RES             : clock, async active-high reset
//   HReq/HWE/HAddr/HAck  : host request (level) and one-cycle data-phase ack
//   DReq/DWE/DAddr/DAck  : DMA request, same protocol
//   Gnt                  : owner of the current access (0 host, 1 DMA)
//   RA, CASel            : multiplexed DRAM address, 1 while RA holds column
//   nRAS/nCAS0/nCAS1/nRWE: DRAM strobes, active low
//   RefOvf               : sticky dropped-refresh flag
// Every output is registered from the next state, so strobes never see a
// combinational path from the request inputs.
module gr8ram_dram_sched
   import gr8ram_pkg::*;
#(
   parameter int REF_PERIOD = 109,
   parameter int REF_MAX    = 3
) (
   input  logic        C7M,
   input  logic        RES,
   input  logic        HReq,
   input  logic        HWE,
   input  logic [22:0] HAddr,
   output logic        HAck,
   input  logic        DReq,
   input  logic        DWE,
   input  logic [22:0] DAddr,
   output logic        DAck,
   output logic        Gnt,
   output logic [10:0] RA,
   output logic        nRAS,
   output logic        nCAS0,
   output logic        nCAS1,
   output logic        nRWE,
   output logic        CASel,
   output logic        RefOvf
);

   localparam int PW = $clog2(REF_MAX + 1);

   sched_state_t  state, nxt, arb_state;
   logic [PW-1:0] pending;
   logic          urgent, ref_done, arb_dma, start;
   logic [22:0]   addr_q, eff_addr;
   logic          we_q, eff_we, eff_gnt;
   strobe_t       stb, stb_n;
   logic [10:0]   ra_n;
   logic          hack_n, dack_n;

   assign ref_done = (state == S_RHOLD);

   gr8ram_ref_timer #(.REF_PERIOD(REF_PERIOD), .REF_MAX(REF_MAX)) u_ref (
      .clk       (C7M),
      .rst       (RES),
      .tick_done (ref_done),
      .pending   (pending),
      .urgent    (urgent),
      .ref_ovf   (RefOvf)
   );

   // fixed-priority pick, used only from IDLE and PRE
   always_comb begin
      arb_state = S_IDLE;
      arb_dma   = GNT_HOST;
      if (urgent)               arb_state = S_RCAS;
      else if (HReq)            arb_state = S_ROW;
      else if (pending != '0)   arb_state = S_RCAS;
      else if (DReq) begin
         arb_state = S_ROW;
         arb_dma   = GNT_DMA;
      end
   end

   always_ff @(posedge C7M or posedge RES) begin
      if (RES) state <= S_IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = S_IDLE;
      case (state)
         S_IDLE, S_PRE: nxt = arb_state;
         S_ROW:         nxt = S_COL;
         S_COL:         nxt = S_HOLD;
         S_HOLD:        nxt = S_PRE;
         S_RCAS:        nxt = S_RRAS;
         S_RRAS:        nxt = S_RHOLD;
         S_RHOLD:       nxt = S_PRE;
         default:       nxt = S_IDLE;
      endcase
   end

   // On a grant the live request is used directly (it is being captured on
   // this same edge); afterwards only the captured copy matters.
   assign start    = (nxt == S_ROW);
   assign eff_gnt  = start ? arb_dma : Gnt;
   assign eff_addr = start ? (arb_dma ? DAddr : HAddr) : addr_q;
   assign eff_we   = start ? (arb_dma ? DWE : HWE) : we_q;

   always_ff @(posedge C7M or posedge RES) begin
      if (RES) begin
         Gnt    <= GNT_HOST;
         addr_q <= '0;
         we_q   <= 1'b0;
      end else if (start) begin
         Gnt    <= arb_dma;
         addr_q <= eff_addr;
         we_q   <= eff_we;
      end
   end

   always_comb begin
      stb_n  = STB_IDLE;
      ra_n   = RA;
      hack_n = 1'b0;
      dack_n = 1'b0;
      case (nxt)
         S_ROW: begin
            stb_n.nras = 1'b0;
            ra_n       = eff_addr[ROW_HI:ROW_LO];
         end
         S_COL, S_HOLD: begin
            stb_n.nras  = 1'b0;
            stb_n.casel = 1'b1;
            stb_n.ncas0 = eff_addr[BANK_BIT];
            stb_n.ncas1 = ~eff_addr[BANK_BIT];
            stb_n.nrwe  = ~eff_we;
            ra_n        = eff_addr[COL_HI:COL_LO];
            if (nxt == S_HOLD) begin
               hack_n = (eff_gnt == GNT_HOST);
               dack_n = (eff_gnt == GNT_DMA);
            end
         end
         S_RCAS: begin
            stb_n.ncas0 = 1'b0;
            stb_n.ncas1 = 1'b0;
         end
         S_RRAS, S_RHOLD: begin
            stb_n.ncas0 = 1'b0;
            stb_n.ncas1 = 1'b0;
            stb_n.nras  = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge C7M or posedge RES) begin
      if (RES) begin
         stb  <= STB_IDLE;
         RA   <= '0;
         HAck <= 1'b0;
         DAck <= 1'b0;
      end else begin
         stb  <= stb_n;
         RA   <= ra_n;
         HAck <= hack_n;
         DAck <= dack_n;
      end
   end

   assign nRAS  = stb.nras;
   assign nCAS0 = stb.ncas0;
   assign nCAS1 = stb.ncas1;
   assign nRWE  = stb.nrwe;
   assign CASel = stb.casel;

endmodule

// File: tb/tb_gr8ram_dram_sched.sv
// Self-checking bench for gr8ram_dram_sched. A slot-level reference model
// (which job owns the DRAM and how far into its 4-cycle slot it is) predicts
// every output each cycle. A second instance with a very short refresh
// period is driven with the same inputs to exercise refresh saturation.
module tb_gr8ram_dram_sched;

   localparam int P = 109;
   localparam int M = 3;

   logic        C7M = 1'b0, RES = 1'b1;
   logic        HReq = 1'b0, HWE = 1'b0, DReq = 1'b0, DWE = 1'b0;
   logic [22:0] HAddr = '0, DAddr = '0;
   logic        HAck, DAck, Gnt, nRAS, nCAS0, nCAS1, nRWE, CASel, RefOvf;
   logic [10:0] RA;
   logic        s_HAck, s_DAck, s_Gnt, s_nRAS, s_nCAS0, s_nCAS1, s_nRWE, s_CASel, s_RefOvf;
   logic [10:0] s_RA;

   gr8ram_dram_sched dut (
      .C7M(C7M), .RES(RES), .HReq(HReq), .HWE(HWE), .HAddr(HAddr), .HAck(HAck),
      .DReq(DReq), .DWE(DWE), .DAddr(DAddr), .DAck(DAck), .Gnt(Gnt), .RA(RA),
      .nRAS(nRAS), .nCAS0(nCAS0), .nCAS1(nCAS1), .nRWE(nRWE), .CASel(CASel),
      .RefOvf(RefOvf));

   gr8ram_dram_sched #(.REF_PERIOD(3), .REF_MAX(3)) dut_s (
      .C7M(C7M), .RES(RES), .HReq(HReq), .HWE(HWE), .HAddr(HAddr), .HAck(s_HAck),
      .DReq(DReq), .DWE(DWE), .DAddr(DAddr), .DAck(s_DAck), .Gnt(s_Gnt), .RA(s_RA),
      .nRAS(s_nRAS), .nCAS0(s_nCAS0), .nCAS1(s_nCAS1), .nRWE(s_nRWE), .CASel(s_CASel),
      .RefOvf(s_RefOvf));

   always #5 C7M = ~C7M;

   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         if (n_bad <= 40) $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // ---- reference model: current job, slot cycle 0..4 (0 = idle) ----
   int          m_ph, m_pend, m_tcnt;
   bit          m_ref, m_gnt, m_we, m_ovf;
   logic [22:0] m_addr;

   task automatic m_reset();
      m_ph = 0; m_ref = 0; m_gnt = 0; m_we = 0; m_addr = '0;
      m_pend = 0; m_tcnt = 0; m_ovf = 0;
   endtask

   task automatic m_edge();
      bit tick, done;
      if (RES) begin m_reset(); return; end
      tick   = (m_tcnt == P - 1);
      m_tcnt = tick ? 0 : m_tcnt + 1;
      done   = m_ref && (m_ph == 3);
      if (m_ph == 0 || m_ph == 4) begin
         if (m_pend == M)    begin m_ref = 1; m_ph = 1; end
         else if (HReq)      begin m_ref = 0; m_gnt = 0; m_addr = HAddr; m_we = HWE; m_ph = 1; end
         else if (m_pend > 0) begin m_ref = 1; m_ph = 1; end
         else if (DReq)      begin m_ref = 0; m_gnt = 1; m_addr = DAddr; m_we = DWE; m_ph = 1; end
         else m_ph = 0;
      end else m_ph++;
      if (tick && !done) begin
         if (m_pend == M) m_ovf = 1;
         else m_pend++;
      end else if (done && !tick) m_pend--;
   endtask

   task automatic m_check();
      bit e_ras = 1, e_c0 = 1, e_c1 = 1, e_we = 1, e_sel = 0, e_ha = 0, e_da = 0;
      if (m_ph >= 1 && m_ph <= 3) begin
         if (m_ref) begin
            e_c0 = 0; e_c1 = 0; e_ras = (m_ph == 1);
         end else begin
            e_ras = 0;
            if (m_ph >= 2) begin
               e_sel = 1; e_c0 = m_addr[22]; e_c1 = !m_addr[22]; e_we = !m_we;
            end
            e_ha = (m_ph == 3) && !m_gnt;
            e_da = (m_ph == 3) && m_gnt;
         end
      end
      chk("nRAS", nRAS, e_ras);  chk("nCAS0", nCAS0, e_c0); chk("nCAS1", nCAS1, e_c1);
      chk("nRWE", nRWE, e_we);   chk("CASel", CASel, e_sel);
      chk("HAck", HAck, e_ha);   chk("DAck", DAck, e_da);   chk("RefOvf", RefOvf, m_ovf);
      if (!m_ref && m_ph >= 1) chk("Gnt", Gnt, m_gnt);
      if (!m_ref && m_ph == 1) chk("RA_row", RA, m_addr[21:11]);
      if (!m_ref && (m_ph == 2 || m_ph == 3)) chk("RA_col", RA, m_addr[10:0]);
   endtask

   // ---- requester behaviour: 0 manual, 1 random, 2 always requesting ----
   int hmode = 0, dmode = 0;
   int ref_seen = 0, ack_seen = 0;
   logic p_ras = 1, p_c0 = 1, p_c1 = 1;

   task automatic drive_req();
      case (hmode)
         1: if (HReq && HAck) begin
               HReq = 1'($urandom_range(0, 1)); HAddr = 23'($urandom); HWE = 1'($urandom_range(0, 1));
            end else if (!HReq) begin
               if ($urandom_range(0, 2) == 0) begin
                  HReq = 1; HAddr = 23'($urandom); HWE = 1'($urandom_range(0, 1));
               end
            end else if ($urandom_range(0, 3) == 0) HAddr = 23'($urandom); // must be ignored
         2: begin HReq = 1; if (HAck) begin HAddr = 23'($urandom); HWE = 1'($urandom_range(0, 1)); end end
         default: ;
      endcase
      case (dmode)
         1: if (DReq && DAck) begin
               DReq = 1'($urandom_range(0, 1)); DAddr = 23'($urandom); DWE = 1'($urandom_range(0, 1));
            end else if (!DReq) begin
               if ($urandom_range(0, 2) == 0) begin
                  DReq = 1; DAddr = 23'($urandom); DWE = 1'($urandom_range(0, 1));
               end
            end else if ($urandom_range(0, 3) == 0) DAddr = 23'($urandom);
         2: begin DReq = 1; if (DAck) begin DAddr = 23'($urandom); DWE = 1'($urandom_range(0, 1)); end end
         default: ;
      endcase
   endtask

   task automatic step();
      @(posedge C7M);
      m_edge();
      @(negedge C7M);
      m_check();
      // refresh signature: CAS already low when RAS falls
      if (!nRAS && p_ras && !p_c0 && !p_c1) ref_seen++;
      if (HAck || DAck) ack_seen++;
      p_ras = nRAS; p_c0 = nCAS0; p_c1 = nCAS1;
      drive_req();
   endtask

   initial begin
      int lat;
      bit hit;
      m_reset();

      // reset state
      repeat (3) step();
      chk("rst_RA", RA, 11'h0);
      chk("rst_Gnt", Gnt, 1'b0);
      chk("rst_s_RefOvf", s_RefOvf, 1'b0);
      RES = 0;

      // idle: two refresh ticks, no acks
      ref_seen = 0; ack_seen = 0;
      repeat (2 * P + 7) step();
      chk("idle_refs", ref_seen, 2);
      chk("idle_acks", ack_seen, 0);

      // host read, bank 1
      HWE = 0; HAddr = 23'h4ABCDE; HReq = 1;
      lat = 0;
      for (int i = 0; i < 20; i++) begin step(); lat++; if (HAck) break; end
      HReq = 0;
      chk("host_lat", lat, 3);
      repeat (4) step();

      // contention: host and DMA rise together right after a tick (pending=1)
      hit = 0;
      for (int i = 0; i < 2 * P; i++) begin
         if (m_tcnt == 0 && m_pend == 1 && m_ph == 0) begin hit = 1; break; end
         step();
      end
      chk("cont_setup", hit, 1'b1);
      HAddr = 23'($urandom); HWE = 1; DAddr = 23'($urandom); DWE = 0;
      HReq = 1; DReq = 1; lat = 0;
      for (int i = 0; i < 30; i++) begin
         step(); lat++;
         if (HAck) HReq = 0;
         if (DAck) break;
      end
      DReq = 0;
      chk("dma_lat", lat, 11);
      repeat (4) step();

      // both requesters saturate the bus: refresh must become urgent
      hmode = 2; dmode = 2;
      repeat (4 * P) step();
      hmode = 0; dmode = 0; HReq = 0; DReq = 0;
      repeat (8) step();
      chk("urg_RefOvf", RefOvf, 1'b0);

      // random traffic
      hmode = 1; dmode = 1;
      repeat (3000) step();
      hmode = 0; dmode = 0; HReq = 0; DReq = 0;
      repeat (8) step();

      // reset in the COL cycle of a host write
      HAddr = 23'($urandom); HWE = 1; HReq = 1;
      hit = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (!m_ref && m_ph == 2 && !m_gnt && m_we) begin hit = 1; break; end
      end
      chk("mw_reach", hit, 1'b1);
      chk("mw_nRWE_low", nRWE, 1'b0);
      RES = 1; HReq = 0;
      #1;
      chk("mw_nRAS", nRAS, 1'b1);   chk("mw_nCAS0", nCAS0, 1'b1);
      chk("mw_nCAS1", nCAS1, 1'b1); chk("mw_nRWE", nRWE, 1'b1);
      chk("mw_HAck", HAck, 1'b0);   chk("mw_CASel", CASel, 1'b0);
      m_reset();
      repeat (2) step();
      RES = 0;
      // model starts from pending=0/timer=0: first refresh only after a full period
      ref_seen = 0; ack_seen = 0;
      repeat (P + 8) step();
      chk("mw_refs", ref_seen, 1);
      chk("mw_acks", ack_seen, 0);

      chk("sat_RefOvf", s_RefOvf, 1'b1);
      chk("end_RefOvf", RefOvf, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
